// File: rtl/mac_pkg.sv
// rtl/mac_pkg.sv - shared FloPoCo word width, exception codes and FSM states
package mac_pkg;

  localparam int W = 34;

  localparam logic [1:0] EXC_ZERO   = 2'b00;
  localparam logic [1:0] EXC_NORMAL = 2'b01;
  localparam logic [1:0] EXC_INF    = 2'b10;
  localparam logic [1:0] EXC_NAN    = 2'b11;

  localparam logic [W-1:0] FP_ZERO = '0;

  typedef enum logic [1:0] {ACCUM, DRAIN, HOLD} state_t;

endpackage

// File: rtl/mac_lane.sv
// rtl/mac_lane.sv - one MAC lane: registered x*w product folded into a FloPoCo accumulator
// Layout: [33:32] exception, [31] sign, [30:23] exponent, [22:0] fraction; no subnormals.
module mac_lane
  import mac_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         load_prod,
  input  logic         acc_en,
  input  logic [W-1:0] x,
  input  logic [W-1:0] w,
  output logic [W-1:0] acc
);

  function automatic logic [W-1:0] fp_mul(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [1:0]         xa, xb;
    logic               sgn, g, st;
    logic [47:0]        p;
    logic [23:0]        sig;
    logic [24:0]        rnd;
    logic [22:0]        frac;
    logic signed [10:0] e;
    logic [W-1:0]       r;
    xa  = a[W-1 -: 2];
    xb  = b[W-1 -: 2];
    sgn = a[31] ^ b[31];
    p   = {1'b1, a[22:0]} * {1'b1, b[22:0]};
    e   = $signed({3'b000, a[30:23]}) + $signed({3'b000, b[30:23]}) - 11'sd127;
    if (p[47]) begin
      sig = p[47:24];
      g   = p[23];
      st  = |p[22:0];
      e   = e + 11'sd1;
    end else begin
      sig = p[46:23];
      g   = p[22];
      st  = |p[21:0];
    end
    rnd = {1'b0, sig} + {24'd0, g & (st | sig[0])};
    // Rounding carry out of the significand bumps the exponent; fraction becomes zero.
    if (rnd[24]) begin
      e    = e + 11'sd1;
      frac = rnd[23:1];
    end else begin
      frac = rnd[22:0];
    end
    if (xa == EXC_NAN || xb == EXC_NAN ||
        (xa == EXC_INF && xb == EXC_ZERO) || (xa == EXC_ZERO && xb == EXC_INF))
      r = {EXC_NAN, 32'd0};
    else if (xa == EXC_INF || xb == EXC_INF)
      r = {EXC_INF, sgn, 31'd0};
    else if (xa == EXC_ZERO || xb == EXC_ZERO)
      r = {EXC_ZERO, sgn, 31'd0};
    else if (e >= 11'sd255)
      r = {EXC_INF, sgn, 31'd0};
    else if (e <= 11'sd0)
      r = {EXC_ZERO, sgn, 31'd0};
    else
      r = {EXC_NORMAL, sgn, e[7:0], frac};
    return r;
  endfunction

  function automatic logic [W-1:0] fp_add(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [1:0]         xa, xb;
    logic [W-1:0]       big, sml, r;
    logic [7:0]         d;
    logic [26:0]        mb, ms, sh, n;
    logic [27:0]        sum;
    logic [4:0]         lz;
    logic               found, st;
    logic [24:0]        rnd;
    logic [22:0]        frac;
    logic signed [10:0] e;
    xa = a[W-1 -: 2];
    xb = b[W-1 -: 2];
    if (a[30:0] >= b[30:0]) begin
      big = a;
      sml = b;
    end else begin
      big = b;
      sml = a;
    end
    d  = big[30:23] - sml[30:23];
    mb = {1'b1, big[22:0], 3'b000};
    ms = {1'b1, sml[22:0], 3'b000};
    // Guard/round bits plus a sticky bit collecting everything shifted out.
    if (d >= 8'd27) begin
      sh = 27'd1;
    end else begin
      sh    = ms >> d;
      st    = |(ms & ~({27{1'b1}} << d));
      sh[0] = sh[0] | st;
    end
    sum = (big[31] ^ sml[31]) ? ({1'b0, mb} - {1'b0, sh}) : ({1'b0, mb} + {1'b0, sh});
    e   = $signed({3'b000, big[30:23]});
    lz    = 5'd0;
    found = 1'b0;
    for (int i = 26; i >= 0; i--) begin
      if (!found) begin
        if (sum[i]) found = 1'b1;
        else        lz = lz + 5'd1;
      end
    end
    if (sum[27]) begin
      n = {sum[27:2], sum[1] | sum[0]};
      e = e + 11'sd1;
    end else begin
      n = sum[26:0] << lz;
      e = e - $signed({6'd0, lz});
    end
    rnd = {1'b0, n[26:3]} + {24'd0, n[2] & (n[1] | n[0] | n[3])};
    if (rnd[24]) begin
      e    = e + 11'sd1;
      frac = rnd[23:1];
    end else begin
      frac = rnd[22:0];
    end
    if (xa == EXC_NAN || xb == EXC_NAN ||
        (xa == EXC_INF && xb == EXC_INF && a[31] != b[31]))
      r = {EXC_NAN, 32'd0};
    else if (xa == EXC_INF)
      r = {EXC_INF, a[31], 31'd0};
    else if (xb == EXC_INF)
      r = {EXC_INF, b[31], 31'd0};
    else if (xa == EXC_ZERO && xb == EXC_ZERO)
      r = {EXC_ZERO, a[31] & b[31], 31'd0};
    else if (xa == EXC_ZERO)
      r = b;
    else if (xb == EXC_ZERO)
      r = a;
    else if (sum == 28'd0)
      r = FP_ZERO;
    else if (e >= 11'sd255)
      r = {EXC_INF, big[31], 31'd0};
    else if (e <= 11'sd0)
      r = {EXC_ZERO, big[31], 31'd0};
    else
      r = {EXC_NORMAL, big[31], e[7:0], frac};
    return r;
  endfunction

  logic [W-1:0] prod;
  logic [W-1:0] prod_nxt;
  logic [W-1:0] sum_nxt;

  assign prod_nxt = fp_mul(x, w);
  assign sum_nxt  = fp_add(acc, prod);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prod <= FP_ZERO;
      acc  <= FP_ZERO;
    end else begin
      if (load_prod) prod <= prod_nxt;
      if (clr)         acc <= FP_ZERO;
      else if (acc_en) acc <= sum_nxt;
    end
  end

endmodule

// File: rtl/mac_lane_array.sv
// rtl/mac_lane_array.sv - broadcast-x multi-lane FP dot-product engine with in/out handshakes
module mac_lane_array
  import mac_pkg::*;
#(
  parameter  int BIT_WIDTH  = 32,
  parameter  int EXTRA_BITS = 2,
  parameter  int LANES      = 4,
  parameter  int VEC_LEN    = 8,
  localparam int LW         = BIT_WIDTH + EXTRA_BITS,
  localparam int CW         = $clog2(VEC_LEN + 1)
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                CLEAR,
  input  logic                IN_VALID,
  output logic                IN_READY,
  input  logic [LW-1:0]       INPUT_SCALER,
  input  logic [LANES*LW-1:0] WEIGHT_SCALER,
  output logic                OUT_VALID,
  input  logic                OUT_READY,
  output logic [LANES*LW-1:0] ACC_RESULT,
  output logic [CW-1:0]       ELEM_CNT
);

  localparam logic [CW-1:0] LAST_CNT = CW'(VEC_LEN - 1);

  state_t state;
  state_t state_nxt;
  logic   prod_valid;
  logic   accept;
  logic   out_fire;
  logic   load_prod;
  logic   acc_clr;

  assign IN_READY  = (state == ACCUM);
  assign OUT_VALID = (state == HOLD);
  assign accept    = IN_VALID && IN_READY;
  assign out_fire  = OUT_VALID && OUT_READY;
  // CLEAR wins over both handshakes at the same edge.
  assign load_prod = accept && !CLEAR;
  assign acc_clr   = CLEAR || out_fire;

  always_comb begin
    state_nxt = state;
    case (state)
      ACCUM:   if (accept && ELEM_CNT == LAST_CNT) state_nxt = DRAIN;
      DRAIN:   state_nxt = HOLD;
      HOLD:    if (out_fire) state_nxt = ACCUM;
      default: state_nxt = ACCUM;
    endcase
    if (CLEAR) state_nxt = ACCUM;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state      <= ACCUM;
      ELEM_CNT   <= '0;
      prod_valid <= 1'b0;
    end else begin
      state      <= state_nxt;
      prod_valid <= load_prod;
      if (acc_clr)     ELEM_CNT <= '0;
      else if (accept) ELEM_CNT <= ELEM_CNT + CW'(1);
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    mac_lane u_lane (
      .clk       (CLK),
      .rst       (RESET),
      .clr       (acc_clr),
      .load_prod (load_prod),
      .acc_en    (prod_valid),
      .x         (INPUT_SCALER),
      .w         (WEIGHT_SCALER[i*LW +: LW]),
      .acc       (ACC_RESULT[i*LW +: LW])
    );
  end

endmodule

// File: tb/tb_mac_lane_array.sv
// tb/tb_mac_lane_array.sv - directed bench for mac_lane_array (2x2 instance and a 1x1 instance)
module tb_mac_lane_array;

  localparam logic [33:0] F_ZERO = 34'd0;
  localparam logic [33:0] F_1_0  = {2'b01, 32'h3f800000};
  localparam logic [33:0] F_2_0  = {2'b01, 32'h40000000};
  localparam logic [33:0] F_3_0  = {2'b01, 32'h40400000};
  localparam logic [33:0] F_5_0  = {2'b01, 32'h40a00000};
  localparam logic [33:0] F_6_0  = {2'b01, 32'h40c00000};
  localparam logic [33:0] F_1_23 = {2'b01, 32'h3f9d70a4};
  localparam logic [33:0] F_7_89 = {2'b01, 32'h40fc7ae1};
  localparam logic [33:0] F_4_56 = {2'b01, 32'h4091eb85};
  localparam logic [33:0] F_10_11 = {2'b01, 32'h4121c28f};
  localparam logic [33:0] F_1_11 = {2'b01, 32'h3f8e147b};
  localparam logic [33:0] F_2_22 = {2'b01, 32'h400e147b};
  localparam logic [33:0] F_3_33 = {2'b01, 32'h40551eb8};
  localparam logic [33:0] F_4_44 = {2'b01, 32'h408e147b};
  localparam logic [33:0] F_INF  = {2'b10, 32'h7f800000};
  localparam logic [33:0] R_P1_L0 = {2'b01, 32'h42aac0df};
  localparam logic [33:0] R_P1_L1 = {2'b01, 32'h4111eb85};
  localparam logic [33:0] R_P2_L0 = {2'b01, 32'h4189fec5};

  logic        clk;
  logic        rst;
  logic        clr;
  logic        in_valid;
  logic        in_ready;
  logic [33:0] x;
  logic [67:0] w;
  logic        out_valid;
  logic        out_ready;
  logic [67:0] acc;
  logic [1:0]  elem_cnt;

  logic        clr1;
  logic        in_valid1;
  logic        in_ready1;
  logic [33:0] x1;
  logic [33:0] w1;
  logic        out_valid1;
  logic        out_ready1;
  logic [33:0] acc1;
  logic [0:0]  elem_cnt1;

  int n_assert = 0;
  int n_fail   = 0;
  logic [67:0] snap;

  mac_lane_array #(.BIT_WIDTH(32), .EXTRA_BITS(2), .LANES(2), .VEC_LEN(2)) dut (
    .CLK(clk), .RESET(rst), .CLEAR(clr), .IN_VALID(in_valid), .IN_READY(in_ready),
    .INPUT_SCALER(x), .WEIGHT_SCALER(w), .OUT_VALID(out_valid), .OUT_READY(out_ready),
    .ACC_RESULT(acc), .ELEM_CNT(elem_cnt)
  );

  mac_lane_array #(.BIT_WIDTH(32), .EXTRA_BITS(2), .LANES(1), .VEC_LEN(1)) dut1 (
    .CLK(clk), .RESET(rst), .CLEAR(clr1), .IN_VALID(in_valid1), .IN_READY(in_ready1),
    .INPUT_SCALER(x1), .WEIGHT_SCALER(w1), .OUT_VALID(out_valid1), .OUT_READY(out_ready1),
    .ACC_RESULT(acc1), .ELEM_CNT(elem_cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_ulp(input string tag, input logic [33:0] obs, input logic [33:0] exp);
    logic [31:0] d;
    logic        ok;
    d  = (obs[31:0] > exp[31:0]) ? obs[31:0] - exp[31:0] : exp[31:0] - obs[31:0];
    ok = (obs[33:31] === exp[33:31]) && (d <= 32'd1);
    n_assert++;
    assert (ok) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (+-1 ulp)", tag, obs, exp);
    end
  endtask

  task automatic feed2(input logic [33:0] xa, input logic [33:0] w0a, input logic [33:0] w1a,
                       input logic [33:0] xb, input logic [33:0] w0b, input logic [33:0] w1b);
    in_valid = 1'b1;
    x = xa;
    w = {w1a, w0a};
    tick();
    x = xb;
    w = {w1b, w0b};
    tick();
    in_valid = 1'b0;
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b0; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    x = F_ZERO; w = '0;
    clr1 = 1'b0; in_valid1 = 1'b0; out_ready1 = 1'b0; x1 = F_ZERO; w1 = F_ZERO;
    #2 rst = 1'b1;
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_acc", 64'(acc[33:0]), 64'(F_ZERO));
    chk("rst_acc_l1", 64'(acc[67:34]), 64'(F_ZERO));
    chk("rst_cnt", 64'(elem_cnt), 64'd0);
    tick();
    tick();
    rst = 1'b0;

    // Pass 1 with per-step timing checks
    in_valid = 1'b1; x = F_1_23; w = {F_1_0, F_4_56};
    tick();
    chk("p1_cnt1", 64'(elem_cnt), 64'd1);
    chk("p1_in_ready_mid", 64'(in_ready), 64'd1);
    x = F_7_89; w = {F_1_0, F_10_11};
    tick();
    in_valid = 1'b0;
    chk("p1_drain_in_ready", 64'(in_ready), 64'd0);
    chk("p1_drain_out_valid", 64'(out_valid), 64'd0);
    chk("p1_drain_cnt", 64'(elem_cnt), 64'd2);
    tick();
    chk("p1_out_valid", 64'(out_valid), 64'd1);
    chk_ulp("p1_lane0", acc[33:0], R_P1_L0);
    chk_ulp("p1_lane1", acc[67:34], R_P1_L1);

    // Back-pressure with stray IN_VALID
    snap = acc;
    in_valid = 1'b1; x = F_3_0; w = {F_3_0, F_3_0};
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_acc_stable", 64'(acc[33:0]), 64'(snap[33:0]));
      chk("bp_acc_stable_l1", 64'(acc[67:34]), 64'(snap[67:34]));
      chk("bp_out_valid", 64'(out_valid), 64'd1);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      chk("bp_cnt", 64'(elem_cnt), 64'd2);
    end
    in_valid = 1'b0;
    handshake();
    chk("hs_out_valid", 64'(out_valid), 64'd0);
    chk("hs_in_ready", 64'(in_ready), 64'd1);
    chk("hs_acc_zero", 64'(acc[33:0]), 64'(F_ZERO));
    chk("hs_cnt", 64'(elem_cnt), 64'd0);

    feed2(F_1_11, F_2_22, F_1_0, F_3_33, F_4_44, F_1_0);
    tick();
    chk("p2_out_valid", 64'(out_valid), 64'd1);
    chk_ulp("p2_lane0", acc[33:0], R_P2_L0);
    chk_ulp("p2_lane1", acc[67:34], F_4_44);
    handshake();

    // CLEAR colliding with the second accept
    in_valid = 1'b1; x = F_1_23; w = {F_1_0, F_4_56};
    tick();
    chk("clr_cnt_before", 64'(elem_cnt), 64'd1);
    x = F_7_89; w = {F_1_0, F_10_11}; clr = 1'b1;
    chk("clr_in_ready_comb", 64'(in_ready), 64'd1);
    tick();
    clr = 1'b0; in_valid = 1'b0;
    chk("clr_cnt", 64'(elem_cnt), 64'd0);
    chk("clr_acc_l0", 64'(acc[33:0]), 64'(F_ZERO));
    chk("clr_acc_l1", 64'(acc[67:34]), 64'(F_ZERO));
    tick();
    chk("clr_acc_no_fold", 64'(acc[33:0]), 64'(F_ZERO));
    chk("clr_out_valid", 64'(out_valid), 64'd0);
    feed2(F_1_23, F_4_56, F_1_0, F_7_89, F_10_11, F_1_0);
    tick();
    chk("clr_p_out_valid", 64'(out_valid), 64'd1);
    chk_ulp("clr_p_lane0", acc[33:0], R_P1_L0);
    chk_ulp("clr_p_lane1", acc[67:34], R_P1_L1);
    handshake();

    // inf*0 -> NaN sticks; inf propagates in the other lane
    in_valid = 1'b1; x = F_INF; w = {F_1_0, F_ZERO};
    tick();
    x = F_1_0; w = {F_1_0, F_1_0};
    tick();
    in_valid = 1'b0;
    chk("nan_mid_l0", 64'(acc[33:32]), 64'd3);
    chk("inf_mid_l1", 64'(acc[33+34 -: 2]), 64'd2);
    tick();
    chk("nan_out_valid", 64'(out_valid), 64'd1);
    chk("nan_final_l0", 64'(acc[33:32]), 64'd3);
    chk("inf_final_l1", 64'(acc[67:66]), 64'd2);
    chk("inf_final_sign", 64'(acc[65]), 64'd0);
    handshake();

    // All-zero weights give FP_ZERO; other lane exact
    feed2(F_2_0, F_ZERO, F_1_0, F_3_0, F_ZERO, F_1_0);
    tick();
    chk("zero_lane0", 64'(acc[33:0]), 64'(F_ZERO));
    chk("sum_lane1", 64'(acc[67:34]), 64'(F_5_0));
    handshake();

    // Asynchronous reset in DRAIN with IN_VALID still high
    in_valid = 1'b1; x = F_1_23; w = {F_1_0, F_4_56};
    tick();
    x = F_7_89; w = {F_1_0, F_10_11};
    tick();
    chk("pre_rst_in_ready", 64'(in_ready), 64'd0);
    rst = 1'b1;
    #1;
    chk("mrst_in_ready", 64'(in_ready), 64'd1);
    chk("mrst_out_valid", 64'(out_valid), 64'd0);
    chk("mrst_cnt", 64'(elem_cnt), 64'd0);
    chk("mrst_acc_l0", 64'(acc[33:0]), 64'(F_ZERO));
    chk("mrst_acc_l1", 64'(acc[67:34]), 64'(F_ZERO));
    tick();
    rst = 1'b0; in_valid = 1'b0;
    tick();
    chk("mrst_idle_acc", 64'(acc[33:0]), 64'(F_ZERO));
    feed2(F_1_11, F_2_22, F_1_0, F_3_33, F_4_44, F_1_0);
    tick();
    chk("mrst_p_out_valid", 64'(out_valid), 64'd1);
    chk_ulp("mrst_p_lane0", acc[33:0], R_P2_L0);
    handshake();

    // VEC_LEN=1 streaming: one result every 3 cycles
    in_valid1 = 1'b1; out_ready1 = 1'b1; x1 = F_2_0; w1 = F_3_0;
    for (int k = 0; k < 9; k++) begin
      chk("v1_in_ready", 64'(in_ready1), (k % 3 == 0) ? 64'd1 : 64'd0);
      chk("v1_out_valid", 64'(out_valid1), (k % 3 == 2) ? 64'd1 : 64'd0);
      chk("v1_cnt", 64'(elem_cnt1), (k % 3 == 0) ? 64'd0 : 64'd1);
      if (k % 3 == 2) chk("v1_result", 64'(acc1), 64'(F_6_0));
      tick();
    end
    in_valid1 = 1'b0; out_ready1 = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
